instr_sequencer: RTL

Program sequencer for the autoencoder datapath. It drives the 4-bit `counter` (program address) into the instruction memory and steps through the program with a fixed three-phase fetch/latch/execute schedule. It issues `enable_sel_mem` to the sector-select registers and `exec_en` to qualify the CU-driven write. It also handles the HALT and LOOP opcodes locally.

---
 rtl/instr_sequencer.sv | 86 ++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: three-phase fetch/latch/execute program sequencer with HALT and counted LOOP.
// Define SEQ_LOOP_EN to compile in LOOP_OP handling; otherwise LOOP_OP runs as a normal instruction.
module instr_sequencer #(
  parameter int PC_W = 4,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [3:0] LOOP_OP = 4'hE
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     instruction,
  output logic [PC_W-1:0] counter,
  output logic            enable_sel_mem,
  output logic            exec_en,
  output logic            busy,
  output logic            done,
  output logic            loop_active
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] counter_n, next_pc, target;
  logic is_halt, is_loop, jump, unused_bits;
  assign next_pc = counter + PC_W'(1);
  assign target = PC_W'(instruction[11:8]);
  assign is_halt = instruction[15:12] == HALT_OP;
  assign unused_bits = ^{instruction[11:0], LOOP_OP, target};
  // The opcode is only known once memory data arrives in LATCH, so this is decoded from state.
  assign enable_sel_mem = state == LATCH && !is_halt && !is_loop;
`ifdef SEQ_LOOP_EN
  logic [3:0] loop_cnt, count;
  logic [PC_W-1:0] loop_addr;
  logic at_end;
  assign count = instruction[7:4];
  assign is_loop = instruction[15:12] == LOOP_OP;
  assign at_end = loop_active && counter == loop_addr;
  assign jump = loop_active ? at_end && loop_cnt != 4'd0 : count != 4'd0;
  always_ff @(posedge clock) begin
    if (reset) begin
      loop_active <= 1'b0;
      loop_cnt <= '0;
      loop_addr <= '0;
    end else if (state_n == DONE) begin
      loop_active <= 1'b0;
    end else if (state == LATCH && is_loop) begin
      if (!loop_active && count != 4'd0) begin
        loop_active <= 1'b1;
        loop_cnt <= count - 4'd1;
        loop_addr <= counter;
      end else if (at_end && loop_cnt == 4'd0) begin
        loop_active <= 1'b0;
      end else if (at_end) begin
        loop_cnt <= loop_cnt - 4'd1;
      end
    end
  end
`else
  assign is_loop = 1'b0;
  assign jump = 1'b0;
  assign loop_active = 1'b0;
`endif
  always_comb begin
    state_n = state == IDLE  ? (start ? FETCH : IDLE) :
              state == FETCH ? LATCH :
              state == LATCH ? (is_halt ? DONE : is_loop ? FETCH : EXEC) :
              state == EXEC  ? FETCH : IDLE;
    counter_n = state == IDLE && start ? START_ADDR :
                state == EXEC ? next_pc :
                state == LATCH && is_loop ? (jump ? target : next_pc) : counter;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      counter <= '0;
      exec_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      counter <= counter_n;
      exec_en <= state_n == EXEC;
      busy <= state_n inside {FETCH, LATCH, EXEC};
      done <= state_n == DONE;
    end
  end
endmodule
